alu_arbiter: RTL and testbench

Round-robin scheduler that shares the single combinational ALU among `NUM_REQ` requesters. Each requester presents `a`/`b`/`op` with a valid/ready handshake. The block grants one requester, drives the ALU from registered operands, captures the result, and returns it through a per-requester response handshake. It sits between the execution clients and the `alu` instance, which connects through the `alu_*` ports.

---
 rtl/alu_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/alu_arbiter.sv | 92 +++++++++
 tb/tb_alu_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU scheduler.
package alu_pkg;
   localparam int WIDTH = 32;
   localparam int OP_W  = 5;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [OP_W-1:0]  op;
   } alu_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_arbiter #(
   parameter int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   logic [IW:0] w_pos;
   logic        w_found;

   always_comb begin
      w_pos   = '0;
      w_found = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = {1'b0, ptr} + (IW+1)'(k);
         if (w_pos >= (IW+1)'(N)) w_pos = w_pos - (IW+1)'(N);
         if (!w_found && req[w_pos[IW-1:0]]) begin
            w_found = 1'b1;
            gnt_idx = w_pos[IW-1:0];
         end
      end
      gnt = w_found ? (N'(1) << gnt_idx) : '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters, one operation in flight.
module alu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = alu_pkg::WIDTH,
   parameter int OP_W    = alu_pkg::OP_W
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_a_i,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_b_i,
   input  logic [NUM_REQ-1:0][OP_W-1:0]   req_op_i,
   output logic [NUM_REQ-1:0]             rsp_valid_o,
   input  logic [NUM_REQ-1:0]             rsp_ready_i,
   output logic [WIDTH-1:0]               rsp_data_o,
   output logic [WIDTH-1:0]               alu_a_o,
   output logic [WIDTH-1:0]               alu_b_o,
   output logic [OP_W-1:0]                alu_op_o,
   input  logic [WIDTH-1:0]               alu_res_i,
   output logic                           busy_o
);
   import alu_pkg::*;

   localparam int IW = $clog2(NUM_REQ);

   alu_arb_state_e   r_state, w_next;
   logic [IW-1:0]    r_ptr, r_gnt, w_gnt_idx;
   logic [NUM_REQ-1:0] w_gnt;
   logic [WIDTH-1:0] r_a, r_b, r_res;
   logic [OP_W-1:0]  r_op;
   logic             w_accept, w_done;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (req_valid_i),
      .ptr     (r_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   assign w_accept = (r_state == IDLE) && (|req_valid_i);
   assign w_done   = (r_state == RESP) && rsp_ready_i[r_gnt];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = EXEC;
         EXEC:    w_next = RESP;
         RESP:    if (w_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Ready is masked by reset so nothing looks accepted while the block is held in reset.
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (r_state == IDLE && rst_ni) req_ready_o = w_gnt;
      if (r_state == RESP)           rsp_valid_o = NUM_REQ'(1) << r_gnt;
      busy_o = (r_state != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr <= '0;
         r_gnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= '0;
         r_res <= '0;
      end else begin
         if (w_accept) begin
            r_gnt <= w_gnt_idx;
            r_a   <= req_a_i[w_gnt_idx];
            r_b   <= req_b_i[w_gnt_idx];
            r_op  <= req_op_i[w_gnt_idx];
         end
         if (r_state == EXEC) r_res <= alu_res_i;
         if (w_done) r_ptr <= (r_gnt == IW'(NUM_REQ-1)) ? '0 : r_gnt + 1'b1;
      end
   end

   assign alu_a_o    = r_a;
   assign alu_b_o    = r_b;
   assign alu_op_o   = r_op;
   assign rsp_data_o = r_res;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: vector table, hand sequences and random ops against a round-robin model.
module tb_alu_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam int O = 5;

   logic              clk, rst_n;
   logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N-1:0][W-1:0] req_a, req_b;
   logic [N-1:0][O-1:0] req_op;
   logic [W-1:0]      rsp_data, alu_a, alu_b, alu_res;
   logic [O-1:0]      alu_op;
   logic              busy;

   int n_chk = 0;
   int n_fail = 0;
   int mptr = 0;

   alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .OP_W(O)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_res_i(alu_res),
      .busy_o(busy)
   );

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [O-1:0] op);
      case (op[1:0])
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a ^ b;
         default: return a & b;
      endcase
   endfunction

   assign alu_res = alu_f(alu_a, alu_b, alu_op);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: first valid requester at or after mptr, wrapping.
   function automatic int model_grant(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(mptr + k) % N]) return (mptr + k) % N;
      return -1;
   endfunction

   task automatic run_txn(input logic [N-1:0] v, input int eg, input logic [W-1:0] er,
                          input int stall, input bit isolate);
      logic [N-1:0] oh;
      oh = N'(1) << eg;
      @(negedge clk);
      req_valid = v;
      #1;
      check("ready_grant", W'(req_ready), W'(oh));
      check("idle_busy", W'(busy), 0);
      @(negedge clk);
      req_valid = '0;
      if (isolate) req_a[eg] = 32'hFFFF_FFFF;
      #1;
      check("exec_busy", W'(busy), 1);
      check("exec_no_rsp", W'(rsp_valid), 0);
      @(negedge clk);
      check("rsp_valid", W'(rsp_valid), W'(oh));
      check("rsp_data", rsp_data, er);
      for (int s = 0; s < stall; s++) begin
         req_valid = '1;
         rsp_ready = ~oh;
         @(negedge clk);
         check("bp_rsp_valid", W'(rsp_valid), W'(oh));
         check("bp_rsp_data", rsp_data, er);
         check("bp_ready", W'(req_ready), 0);
         check("bp_busy", W'(busy), 1);
      end
      req_valid = '0;
      rsp_ready = oh;
      @(negedge clk);
      rsp_ready = '0;
      check("rsp_drop", W'(rsp_valid), 0);
      mptr = (eg + 1) % N;
   endtask

   typedef struct {
      logic [N-1:0] v;
      logic [W-1:0] a, b;
      logic [O-1:0] op;
      int           eg;
      logic [W-1:0] er;
      int           stall;
      bit           iso;
   } vec_t;

   vec_t tbl[8];

   initial begin
      rst_n = 1'b0;
      req_valid = '1;
      rsp_ready = '1;
      req_a = '0; req_b = '0; req_op = '0;
      #2;
      check("rst_ready", W'(req_ready), 0);
      check("rst_rsp_valid", W'(rsp_valid), 0);
      check("rst_busy", W'(busy), 0);
      check("rst_data", rsp_data, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_op", W'(alu_op), 0);
      req_valid = '0;
      rsp_ready = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Requester i sees a + (i<<8); expectations follow the round-robin order from ptr=0.
      tbl[0] = '{4'b0001, 32'd5,     32'd3,     5'd0, 0, 32'd8,     0,  1'b0};
      tbl[1] = '{4'b1011, 32'd10,    32'd4,     5'd1, 1, 32'd262,   0,  1'b0};
      tbl[2] = '{4'b1011, 32'd1,     32'd2,     5'd0, 3, 32'd771,   10, 1'b0};
      tbl[3] = '{4'b1011, 32'hF0,    32'hFF,    5'd2, 0, 32'h0F,    0,  1'b1};
      tbl[4] = '{4'b0100, 32'hFF00,  32'h0FF0,  5'd3, 2, 32'h0100,  2,  1'b0};
      tbl[5] = '{4'b1001, 32'd7,     32'd7,     5'd0, 3, 32'h30E,   0,  1'b1};
      tbl[6] = '{4'b1001, 32'd7,     32'd7,     5'd1, 0, 32'd0,     0,  1'b0};
      tbl[7] = '{4'b1111, 32'd100,   32'd1,     5'd1, 1, 32'd355,   1,  1'b0};
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) begin
            req_a[i]  = tbl[t].a + W'(i << 8);
            req_b[i]  = tbl[t].b;
            req_op[i] = tbl[t].op;
         end
         run_txn(tbl[t].v, tbl[t].eg, tbl[t].er, tbl[t].stall, tbl[t].iso);
      end

      // Reset during EXEC: everything clears, no late response, arbitration restarts at 0.
      @(negedge clk);
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      check("pre_rst_busy", W'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", W'(busy), 0);
      check("mid_rst_rsp", W'(rsp_valid), 0);
      check("mid_rst_alu_a", alu_a, 0);
      check("mid_rst_alu_b", alu_b, 0);
      check("mid_rst_data", rsp_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_no_rsp", W'(rsp_valid), 0);
      end
      mptr = 0;
      for (int i = 0; i < N; i++) begin
         req_a[i] = W'(i + 1); req_b[i] = 32'd10; req_op[i] = 5'd0;
      end
      run_txn(4'b1111, 0, 32'd11, 0, 1'b0);

      // Random traffic against the model.
      for (int r = 0; r < 150; r++) begin
         logic [N-1:0] v;
         int g;
         v = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            req_a[i]  = $urandom;
            req_b[i]  = $urandom;
            req_op[i] = O'($urandom);
         end
         g = model_grant(v);
         run_txn(v, g, alu_f(req_a[g], req_b[g], req_op[g]), $urandom_range(0, 3),
                 bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
